// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of the single-ported data memory between the
// CPU MEM stage (port 0) and an auxiliary master (port 1), with post-reset zero-fill.
module dm_arbiter #(
    parameter int unsigned DEPTH_LOG2     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] pc0,
    input  logic [31:0] pc1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    output logic        mem_clr,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [DEPTH_LOG2-1:0] CLR_LAST = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_q, clr_d;
    logic                  rr_last_q, rr_last_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DW-1:0]         rdata0_q, rdata0_d;
    logic [DW-1:0]         rdata1_q, rdata1_d;
    logic                  pick1;

    // State register; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_q     <= '0;
            rr_last_q <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            rr_last_q <= rr_last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Next-state, arbitration and memory-side muxing.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        rr_last_d = rr_last_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_clr   = 1'b0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_pc    = pc0;
        pick1     = req1 && (!req0 || !rr_last_q);

        if (!reset) begin
            // Outputs held at their reset values while reset is asserted.
            busy      = CLEAR_ON_RESET;
            mem_we    = CLEAR_ON_RESET;
            mem_clr   = CLEAR_ON_RESET;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_pc    = '0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    busy      = 1'b1;
                    mem_we    = 1'b1;
                    mem_clr   = 1'b1;
                    mem_addr  = AW'({clr_q, 2'b00});
                    mem_wdata = '0;
                    mem_pc    = '0;
                    clr_d     = clr_q + 1'b1;
                    if (clr_q == CLR_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    gnt1 = pick1;
                    gnt0 = req0 && !pick1;
                    if (gnt1) begin
                        mem_we    = we1;
                        mem_addr  = addr1;
                        mem_wdata = wdata1;
                        mem_pc    = pc1;
                        rr_last_d = 1'b1;
                        rvalid1_d = !we1;
                        if (!we1) begin
                            rdata1_d = mem_rdata;
                        end
                    end else if (gnt0) begin
                        mem_we    = we0;
                        rr_last_d = 1'b0;
                        rvalid0_d = !we0;
                        if (!we0) begin
                            rdata0_d = mem_rdata;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of dm_arbiter with a word-memory model attached;
// a second instance covers the no-clear configuration.
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_we, mem_clr;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_pc, mem_rdata;

    logic        b_req0;
    logic [31:0] b_addr0;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_mem_we, b_mem_clr;
    logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_pc, b_mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    dm_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .pc0(pc0), .pc1(pc1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_pc(mem_pc), .mem_clr(mem_clr), .mem_rdata(mem_rdata)
    );

    dm_arbiter #(.DEPTH_LOG2(12), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(b_addr0), .addr1(32'h0), .wdata0(32'h0), .wdata1(32'h0),
        .pc0(32'h0), .pc1(32'h0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1), .busy(b_busy),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_pc(b_mem_pc), .mem_clr(b_mem_clr), .mem_rdata(b_mem_rdata)
    );

    // Word memory: combinational read, write on the rising edge; preloaded with junk.
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;
    assign mem_rdata   = mem[mem_addr[13:2]];
    assign b_mem_rdata = b_mem_addr ^ 32'hA5A5_0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; pc0 = '0; pc1 = '0;
        b_req0 = 1'b0; b_addr0 = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_gnt0", 32'(gnt0), 32'd0);
        check_eq("rst_rvalid0", 32'(rvalid0), 32'd0);
        check_eq("rst_rdata0", rdata0, 32'h0);
        check_eq("rst_rdata1", rdata1, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_mem_we", 32'(mem_we), 32'd1);
        check_eq("rst_mem_clr", 32'(mem_clr), 32'd1);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_b_busy", 32'(b_busy), 32'd0);
        check_eq("rst_b_mem_we", 32'(b_mem_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Runs n fill cycles starting at post-reset cycle 0 (called at posedge+1).
    task automatic fill_run(input int n, input bit first);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq($sformatf("fill_busy[%0d]", k), 32'(busy), 32'd1);
            check_eq($sformatf("fill_addr[%0d]", k), mem_addr, 32'(k * 4));
            check_eq($sformatf("fill_we_clr[%0d]", k), 32'({mem_we, mem_clr}), 32'd3);
            check_eq($sformatf("fill_wdata[%0d]", k), mem_wdata, 32'h0);
            check_eq($sformatf("fill_gnt[%0d]", k), 32'({gnt0, gnt1}), 32'd0);
            if (first && k == 0) begin
                check_eq("nc_gnt0", 32'(b_gnt0), 32'd1);
                check_eq("nc_busy", 32'(b_busy), 32'd0);
                check_eq("nc_mem_addr", b_mem_addr, 32'h8);
            end
            if (first && k == 1) begin
                check_eq("nc_rvalid0", 32'(b_rvalid0), 32'd1);
                check_eq("nc_rdata0", b_rdata0, 32'hA5A5_0008);
            end
            @(posedge clk); #1;
            if (first && k == 0) b_req0 = 1'b0;
        end
    endtask

    logic [31:0] a0 [3] = '{32'h10, 32'h40, 32'h48};
    logic [31:0] a1 [3] = '{32'h44, 32'h4C, 32'h20};
    logic [31:0] e0 [3] = '{32'h1234_5678, 32'hB000_0000, 32'hB000_0002};
    logic [31:0] e1 [3] = '{32'hB000_0001, 32'hB000_0003, 32'h0};

    initial begin
        int p0, p1;
        do_reset();
        // Requests during the fill are ignored; port 0 keeps asking for 0x20.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        b_req0 = 1'b1; b_addr0 = 32'h8;
        fill_run(4096, 1'b1);

        // Cycle 4096: first grant.
        @(negedge clk);
        check_eq("c4096_busy", 32'(busy), 32'd0);
        check_eq("c4096_gnt0", 32'(gnt0), 32'd1);
        check_eq("c4096_mem_we", 32'(mem_we), 32'd0);
        check_eq("c4096_mem_addr", mem_addr, 32'h20);
        @(posedge clk); #1;
        we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h1234_5678; pc0 = 32'h100;
        @(negedge clk);
        check_eq("clr_rvalid0", 32'(rvalid0), 32'd1);
        check_eq("clr_rdata0", rdata0, 32'h0);
        check_eq("wr_gnt0", 32'(gnt0), 32'd1);
        check_eq("wr_mem_we", 32'(mem_we), 32'd1);
        check_eq("wr_mem_addr", mem_addr, 32'h10);
        check_eq("wr_mem_pc", mem_pc, 32'h100);
        @(posedge clk); #1;
        we0 = 1'b0;
        @(negedge clk);
        check_eq("rd_gnt0", 32'(gnt0), 32'd1);
        check_eq("rd_mem_we", 32'(mem_we), 32'd0);
        check_eq("wr_no_rvalid0", 32'(rvalid0), 32'd0);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        check_eq("rd_rvalid0", 32'(rvalid0), 32'd1);
        check_eq("rd_rdata0", rdata0, 32'h1234_5678);
        check_eq("rd_rvalid1", 32'(rvalid1), 32'd0);
        check_eq("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
        check_eq("idle_mem_we", 32'(mem_we), 32'd0);

        // Port 1 alone: four back-to-back writes.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req1 = 1'b1; we1 = 1'b1;
            addr1 = 32'h40 + 32'(4 * k); wdata1 = 32'hB000_0000 + 32'(k); pc1 = 32'h200 + 32'(4 * k);
            @(negedge clk);
            check_eq($sformatf("p1wr_gnt[%0d]", k), 32'({gnt0, gnt1}), 32'd1);
            check_eq($sformatf("p1wr_we[%0d]", k), 32'(mem_we), 32'd1);
            check_eq($sformatf("p1wr_pc[%0d]", k), mem_pc, 32'h200 + 32'(4 * k));
            check_eq($sformatf("p1wr_addr[%0d]", k), mem_addr, 32'h40 + 32'(4 * k));
            check_eq($sformatf("p1wr_wdata[%0d]", k), mem_wdata, 32'hB000_0000 + 32'(k));
            check_eq($sformatf("p1wr_clr[%0d]", k), 32'(mem_clr), 32'd0);
        end

        // Continuous contention: six reads, grants alternate starting with port 0.
        p0 = 0; p1 = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            we0 = 1'b0; we1 = 1'b0;
            req0 = (i < 6) && (p0 < 3);
            req1 = (i < 6) && (p1 < 3);
            if (p0 < 3) addr0 = a0[p0];
            if (p1 < 3) addr1 = a1[p1];
            @(negedge clk);
            if (i < 6) begin
                check_eq($sformatf("rr_gnt0[%0d]", i), 32'(gnt0), 32'(i % 2 == 0));
                check_eq($sformatf("rr_gnt1[%0d]", i), 32'(gnt1), 32'(i % 2 == 1));
            end
            check_eq($sformatf("rr_rvalid0[%0d]", i), 32'(rvalid0), 32'(i > 0 && (i - 1) % 2 == 0));
            check_eq($sformatf("rr_rvalid1[%0d]", i), 32'(rvalid1), 32'(i > 0 && (i - 1) % 2 == 1));
            if (i > 0 && (i - 1) % 2 == 0) check_eq($sformatf("rr_rdata0[%0d]", i), rdata0, e0[(i - 1) / 2]);
            if (i > 0 && (i - 1) % 2 == 1) check_eq($sformatf("rr_rdata1[%0d]", i), rdata1, e1[(i - 1) / 2]);
            if (i < 6) begin
                if (i % 2 == 0) p0++;
                else p1++;
            end
        end

        // Reset pulse in the middle of a fill restarts it from word 0.
        do_reset();
        fill_run(2000, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        fill_run(4096, 1'b0);
        @(negedge clk);
        check_eq("refill_busy_end", 32'(busy), 32'd0);
        check_eq("refill_mem_we_end", 32'(mem_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-ported word data memory (4096 × 32, combinational read, write on rising edge) between two requesters: port 0 (CPU MEM stage) and port 1 (auxiliary loader/debug master). It sits between the pipeline's MEM stage and the data memory. After reset it sequences a word-by-word zero-fill of the memory, replacing the single-cycle bulk clear. It grants at most one access per cycle using round-robin arbitration and returns read data registered one cycle after the grant.

## Interface
- DEPTH_LOG2, 12, log2 of memory depth in words; the clear walks 2^DEPTH_LOG2 words.
- CLEAR_ON_RESET, 1, 1 = run the zero-fill after reset; 0 = skip it and go straight to IDLE.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled at the rising edge of clk.
- req0 / req1  in  1  access request from port 0 / port 1.
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN.
- addr0 / addr1  in  32  byte address; bits [DEPTH_LOG2+1:2] select the word.
- wdata0 / wdata1  in  32  write data.
- pc0 / pc1  in  32  PC tag forwarded to the memory write log.
- gnt0 / gnt1  out  1  combinational grant; the access is performed in this cycle.
- rvalid0 / rvalid1  out  1  registered; read data valid for one cycle.
- rdata0 / rdata1  out  32  registered read data; holds its value until the next read for that port.
- busy  out  1  high while the zero-fill runs; the pipeline stalls on busy.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_pc  out  32  PC tag to the memory.
- mem_clr  out  1  high during zero-fill writes; the memory suppresses its write log when set.
- mem_rdata  in  32  combinational memory read data.

## Operation
- States: CLEAR, IDLE.
- While reset = 0:
  - state ← CLEAR if CLEAR_ON_RESET, else IDLE.
  - clr_cnt ← 0; rr_last ← 1.
  - rvalid0/1 ← 0; rdata0/1 ← 0.
- CLEAR:
  - Outputs: mem_we = 1, mem_clr = 1, mem_addr = {clr_cnt, 2'b00} zero-extended, mem_wdata = 0, mem_pc = 0, busy = 1, gnt0/1 = 0.
  - Requests are ignored, not queued.
  - clr_cnt increments each cycle. When clr_cnt = 2^DEPTH_LOG2 − 1, go to IDLE.
- IDLE:
  - busy = 0, mem_clr = 0.
  - Arbitration, decided combinationally from the current reqN:
    - Only one requester: it wins.
    - Both requesting: the port ≠ rr_last wins.
    - No request: no grant.
  - The winner's we/addr/wdata/pc drive the mem_* outputs; mem_we = winner's we.
  - With no grant: mem_we = 0; mem_addr/mem_wdata/mem_pc = port 0 values.
  - On a grant: rr_last ← winner.
  - On a granted read: rdataN ← mem_rdata and rvalidN ← 1 at the next edge; otherwise rvalidN ← 0.
  - Granted writes never assert rvalid.
- Requester rule: hold reqN and its payload until gnt is seen high. Deasserting reqN without a grant withdraws the request with no side effects.
- No address range or alignment checking; addr[1:0] pass through unchanged.
- The display PC is taken from the granted port only.

## Timing
- Reset values:
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0.
  - busy = CLEAR_ON_RESET.
  - mem_we = CLEAR_ON_RESET, mem_clr = CLEAR_ON_RESET.
  - mem_addr = 0, mem_wdata = 0.
- Zero-fill:
  - The first post-reset cycle writes word 0. Word k is written in post-reset cycle k.
  - busy is high for exactly 2^DEPTH_LOG2 cycles (4096 at default). The first grant is possible in cycle 4096.
- Access latency:
  - Grant in cycle N. A write is visible to a read issued in cycle N+1.
  - Read data: rvalid/rdata in cycle N+1.
- Back-to-back: a port can be granted every cycle when it is the only requester. Under continuous contention, grants alternate 0, 1, 0, 1, ….
- Reset mid-clear: the counter restarts at 0 and the full fill reruns.
- Reset in IDLE: a pending rvalid is dropped.
- reset low for one edge is sufficient.

## Test plan
- Reset, CLEAR_ON_RESET = 1, no requests → busy high for 4096 cycles; mem_addr steps 0x0, 0x4, …, 0x3FFC with mem_we = mem_clr = 1; busy = 0 in cycle 4096; no grant while busy even with req0 = 1.
- Port 0 writes 0x1234_5678 to 0x0000_0010, then reads 0x10 the next cycle → gnt0 in both cycles; rvalid0 = 1 and rdata0 = 0x1234_5678 one cycle after the read grant; rvalid1 stays 0.
- req0 and req1 held high for 6 reads at different addresses → grants 0, 1, 0, 1, 0, 1; each rvalidN pulses one cycle after its grant with the correct data.
- Port 1 alone issues 4 consecutive writes → gnt1 every cycle; mem_pc = pc1 on each write; mem_clr = 0.
- reset pulsed low at fill cycle 2000 → clr_cnt restarts; mem_addr = 0x0 on the first post-reset cycle; busy stays high another 4096 cycles.
- CLEAR_ON_RESET = 0 → busy = 0 and mem_we = 0 right after reset; req0 read of 0x8 is granted in the first post-reset cycle; rvalid0 follows in the next cycle.
